tess_domain_gen: RTL
====================

Name: tess_domain_gen

Overview:
Parametrised next-generation fixed-function tessellator domain-point generator. It accepts one patch configuration: mode triangle, quad or isoline, with Q16.16 tessellation factors. It emits the patch's domain coordinates as a valid/ready vertex stream with index and last-vertex tagging. Coordinates are computed exactly with an incremental step/remainder accumulator, so no per-vertex divide is needed. It sits between the hull-stage patch queue and the domain-shader vertex launcher.

Parameters:
MAX_LEVEL, 64, maximum integer tessellation level after clamping (1..255)
FRAC_W, 16, fractional bits of emitted coordinates; unity S = 2^FRAC_W (1..16)
IDX_W, 16, width of out_idx; must hold (MAX_LEVEL+1)^2-1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_valid  in  1  patch configuration valid
cfg_ready  out  1  block idle and able to accept a configuration
prim_mode  in  2  0=triangle, 1=quad, 2=isoline, 3=reserved
outer0  in  32  signed Q16.16 factor; level N (tri) or Nu (quad/iso)
outer1  in  32  signed Q16.16 factor; Nv (quad: v segments; iso: line count); ignored for tri
coord0  out  32  tri: b0; quad/iso: u; scaled by S
coord1  out  32  tri: b1; quad/iso: v
coord2  out  32  tri: b2; quad/iso: 0
out_idx  out  IDX_W  vertex index within patch, starting at 0
out_last  out  1  final vertex of patch
out_valid  out  1  vertex valid
out_ready  in  1  consumer ready
busy  out  1  high in any state except IDLE
cull_pulse  out  1  one-cycle pulse when a patch is culled

Behaviour:
- Reset (async): state IDLE; cfg_ready=1; out_valid, out_last, busy, cull_pulse=0; coords and out_idx=0. Asserting reset mid-patch abandons the patch; no partial output resumes.
- States: IDLE -> CHECK -> DIV_U -> DIV_V -> GEN -> IDLE.
- IDLE: cfg_ready=1. When cfg_valid&&cfg_ready, register mode and factors, set cfg_ready=0, go to CHECK.
- CHECK: cull if prim_mode=3, or any used factor ≤ 0 as signed (tri uses outer0 only; quad/iso use both). On cull: cull_pulse=1 for exactly one cycle, emit no vertex, return to IDLE.
- Otherwise derive each level L = (raw+0x8000)>>16. If L=0, L=1. If L>MAX_LEVEL, L=MAX_LEVEL.
- DIV_U/DIV_V: restoring divider, one quotient bit per cycle, exactly FRAC_W+1 cycles each. Produces q=floor(S/L) and r=S mod L. DIV_V is skipped for tri.
- First out_valid asserts no later than 2*FRAC_W+6 cycles after cfg acceptance.
- Coordinates: c(k) = floor(k*S/L), computed incrementally as acc+=q and rem+=r; when rem≥L, subtract L and add 1. Reset to 0 at each outer-loop restart. c(L) must equal S exactly.
- Triangle: i=0..N outer, j=0..N-i inner. coord1=c(i), coord2=c(j), coord0=S-coord1-coord2. Count (N+1)(N+2)/2.
- Quad: v-index 0..Nv outer, u-index 0..Nu inner. coord0=c_u, coord1=c_v. Count (Nu+1)(Nv+1).
- Isoline: line 0..Nv-1 outer, u 0..Nu inner. coord1=c_v(line), so v=1 is never emitted. Count Nv(Nu+1).
- Output handshake: registered outputs. A new vertex loads when !out_valid || out_ready. While out_valid&&!out_ready, coords, out_idx and out_last hold stable.
- Throughput: one vertex per cycle when out_ready is held high.
- out_idx increments per accepted vertex. out_last=1 only on the final vertex.
- Patch end: on the out_last handshake, out_valid drops the next cycle (unless nothing follows) and the state goes to IDLE. cfg_ready=1 the cycle after the final handshake.
- Overlap: no acceptance of a new cfg while busy.
- Inputs outer0/outer1/prim_mode are sampled only at acceptance; later changes are ignored.

Test Plan:
- Tri, outer0=0x0002_0000 (N=2), out_ready=1 -> 6 vertices (b0,b1,b2): (65536,0,0), (32768,0,32768), (0,0,65536), (32768,32768,0), (0,32768,32768), (0,65536,0); out_idx 0..5; out_last only on idx 5; cfg_ready=1 afterwards.
- Quad, outer0=0x0003_0000, outer1=0x0001_0000 -> 8 vertices; u sequence 0, 21845, 43690, 65536 for v=0 then v=65536; coord2=0 throughout.
- Rounding/clamp: outer0=0x0002_8000 -> N=3 (10 tri vertices); outer0=0x0000_4000 -> N=1 (3 vertices); outer0=0x00C8_0000 -> N=64, 2145 vertices, last out_idx=2144.
- Cull: tri outer0=0 -> cull_pulse for one cycle, no out_valid; quad outer1=0xFFFF_0000 -> culled; prim_mode=3 -> culled; next cfg accepted normally after each.
- Backpressure: quad N=4x4 with out_ready randomly low 50% -> 25 vertices in order, no drops or duplicates, outputs stable while stalled.
- Isoline outer0=0x0002_0000, outer1=0x0004_0000 -> 12 vertices, v in {0, 16384, 32768, 49152}, never 65536. Assert rst_n low at vertex 5 -> all outputs return to reset values immediately; a fresh cfg then runs correctly from idx 0.

Source files
------------

// File: rtl/tess_domain_gen.sv
// Tessellator domain-point generator: turns one patch configuration into a
// valid/ready stream of exact fixed-point domain coordinates.
//   state | meaning
//   IDLE  | waiting for a patch configuration
//   CHECK | cull test and level derivation
//   DIV_U | restoring divide S/Nu (also used for tri level N)
//   DIV_V | restoring divide S/Nv (skipped for tri)
//   GEN   | vertex emission with output backpressure
module tess_domain_gen #(
  parameter int MAX_LEVEL = 64,
  parameter int FRAC_W    = 16,
  parameter int IDX_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       prim_mode,
  input  logic [31:0]      outer0,
  input  logic [31:0]      outer1,
  output logic [31:0]      coord0,
  output logic [31:0]      coord1,
  output logic [31:0]      coord2,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             cull_pulse
);

  localparam int CW = FRAC_W + 1;
  localparam int LW = $clog2(MAX_LEVEL + 1);
  localparam int RW = LW + 1;
  localparam int NW = $clog2(FRAC_W + 2);
  localparam logic [CW-1:0] S_ONE = {1'b1, {FRAC_W{1'b0}}};

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_DIV_U = 3'd2;
  localparam logic [2:0] ST_DIV_V = 3'd3;
  localparam logic [2:0] ST_GEN   = 3'd4;

  // Round Q16.16 to nearest integer, then clamp into 1..MAX_LEVEL.
  function automatic logic [LW-1:0] level_of(input logic [31:0] raw);
    logic [16:0] l;
    l = 17'((33'(raw) + 33'h0_0000_8000) >> 16);
    if (l == 17'd0) return LW'(1);
    if (l > 17'(MAX_LEVEL)) return LW'(MAX_LEVEL);
    return LW'(l);
  endfunction

  logic [2:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [31:0]      o0_q, o0_d, o1_q, o1_d;
  logic [LW-1:0]    lvl_u_q, lvl_u_d, lvl_v_q, lvl_v_d;
  logic [CW-1:0]    q_u_q, q_u_d, q_v_q, q_v_d;
  logic [LW-1:0]    r_u_q, r_u_d, r_v_q, r_v_d;
  logic [LW-1:0]    div_rem_q, div_rem_d;
  logic [CW-1:0]    div_quo_q, div_quo_d;
  logic [NW-1:0]    div_cnt_q, div_cnt_d;
  logic [LW-1:0]    on_q, on_d, in_q, in_d;
  logic [CW-1:0]    co_acc_q, co_acc_d, ci_acc_q, ci_acc_d;
  logic [LW-1:0]    co_rem_q, co_rem_d, ci_rem_q, ci_rem_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [CW-1:0]    coord0_q, coord0_d, coord1_q, coord1_d, coord2_q, coord2_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d, out_valid_q, out_valid_d;
  logic             cull_pulse_q, cull_pulse_d;

  logic             cull;
  logic [LW-1:0]    div_l, div_rem_nx;
  logic             div_bit, div_ge;
  logic [RW-1:0]    div_trial;
  logic [CW-1:0]    div_quo_nx;
  logic [RW-1:0]    ci_sum, co_sum;
  logic             ci_wrap, co_wrap;
  logic [LW-1:0]    ci_rem_nx, co_rem_nx;
  logic [CW-1:0]    ci_acc_nx, co_acc_nx;
  logic [LW-1:0]    outer_max, inner_max;
  logic             is_last, load;

  assign cull = (mode_q == 2'd3) || ($signed(o0_q) <= 32'sd0) ||
                ((mode_q != 2'd0) && ($signed(o1_q) <= 32'sd0));

  // S has a single set bit, so the dividend stream is one '1' followed by zeros.
  assign div_l      = (state_q == ST_DIV_V) ? lvl_v_q : lvl_u_q;
  assign div_bit    = (div_cnt_q == NW'(FRAC_W));
  assign div_trial  = {div_rem_q, div_bit};
  assign div_ge     = (div_trial >= {1'b0, div_l});
  assign div_rem_nx = div_ge ? LW'(div_trial - {1'b0, div_l}) : LW'(div_trial);
  assign div_quo_nx = CW'({div_quo_q, div_ge});

  // Tri reuses the u quotient/remainder for its outer loop (copied into v).
  assign ci_sum    = {1'b0, ci_rem_q} + {1'b0, r_u_q};
  assign ci_wrap   = (ci_sum >= {1'b0, lvl_u_q});
  assign ci_rem_nx = ci_wrap ? LW'(ci_sum - {1'b0, lvl_u_q}) : LW'(ci_sum);
  assign ci_acc_nx = ci_acc_q + q_u_q + CW'(ci_wrap);
  assign co_sum    = {1'b0, co_rem_q} + {1'b0, r_v_q};
  assign co_wrap   = (co_sum >= {1'b0, lvl_v_q});
  assign co_rem_nx = co_wrap ? LW'(co_sum - {1'b0, lvl_v_q}) : LW'(co_sum);
  assign co_acc_nx = co_acc_q + q_v_q + CW'(co_wrap);

  assign outer_max = (mode_q == 2'd2) ? lvl_v_q - LW'(1) : lvl_v_q;
  assign inner_max = (mode_q == 2'd0) ? lvl_u_q - on_q : lvl_u_q;
  assign is_last   = (on_q == outer_max) && (in_q == inner_max);
  assign load      = (state_q == ST_GEN) && !done_q && (!out_valid_q || out_ready);

  always_comb begin
    state_d = state_q;     mode_d = mode_q;       o0_d = o0_q;       o1_d = o1_q;
    lvl_u_d = lvl_u_q;     lvl_v_d = lvl_v_q;     q_u_d = q_u_q;     q_v_d = q_v_q;
    r_u_d = r_u_q;         r_v_d = r_v_q;         div_rem_d = div_rem_q;
    div_quo_d = div_quo_q; div_cnt_d = div_cnt_q; on_d = on_q;       in_d = in_q;
    co_acc_d = co_acc_q;   ci_acc_d = ci_acc_q;   co_rem_d = co_rem_q;
    ci_rem_d = ci_rem_q;   idx_d = idx_q;         done_d = done_q;
    coord0_d = coord0_q;   coord1_d = coord1_q;   coord2_d = coord2_q;
    out_idx_d = out_idx_q; out_last_d = out_last_q; out_valid_d = out_valid_q;
    cull_pulse_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          mode_d  = prim_mode;
          o0_d    = outer0;
          o1_d    = outer1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cull) begin
          cull_pulse_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          lvl_u_d   = level_of(o0_q);
          lvl_v_d   = (mode_q == 2'd0) ? level_of(o0_q) : level_of(o1_q);
          div_rem_d = '0;
          div_quo_d = '0;
          div_cnt_d = NW'(FRAC_W);
          on_d = '0;      in_d = '0;
          co_acc_d = '0;  ci_acc_d = '0;
          co_rem_d = '0;  ci_rem_d = '0;
          idx_d = '0;     done_d = 1'b0;
          state_d = ST_DIV_U;
        end
      end
      ST_DIV_U, ST_DIV_V: begin
        div_rem_d = div_rem_nx;
        div_quo_d = div_quo_nx;
        div_cnt_d = div_cnt_q - NW'(1);
        if (div_cnt_q == '0) begin
          div_rem_d = '0;
          div_quo_d = '0;
          div_cnt_d = NW'(FRAC_W);
          q_v_d     = div_quo_nx;
          r_v_d     = div_rem_nx;
          if (state_q == ST_DIV_U) begin
            q_u_d   = div_quo_nx;
            r_u_d   = div_rem_nx;
            state_d = (mode_q == 2'd0) ? ST_GEN : ST_DIV_V;
          end else begin
            state_d = ST_GEN;
          end
        end
      end
      ST_GEN: begin
        if (out_valid_q && out_ready && out_last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_last_d  = is_last;
      out_idx_d   = idx_q;
      idx_d       = idx_q + IDX_W'(1);
      done_d      = is_last;
      if (mode_q == 2'd0) begin
        coord0_d = S_ONE - co_acc_q - ci_acc_q;
        coord1_d = co_acc_q;
        coord2_d = ci_acc_q;
      end else begin
        coord0_d = ci_acc_q;
        coord1_d = co_acc_q;
        coord2_d = '0;
      end
      if (in_q == inner_max) begin
        in_d     = '0;
        ci_acc_d = '0;
        ci_rem_d = '0;
        on_d     = on_q + LW'(1);
        co_acc_d = co_acc_nx;
        co_rem_d = co_rem_nx;
      end else begin
        in_d     = in_q + LW'(1);
        ci_acc_d = ci_acc_nx;
        ci_rem_d = ci_rem_nx;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;  mode_q <= '0;     o0_q <= '0;       o1_q <= '0;
      lvl_u_q <= '0;       lvl_v_q <= '0;    q_u_q <= '0;      q_v_q <= '0;
      r_u_q <= '0;         r_v_q <= '0;      div_rem_q <= '0;  div_quo_q <= '0;
      div_cnt_q <= '0;     on_q <= '0;       in_q <= '0;       co_acc_q <= '0;
      ci_acc_q <= '0;      co_rem_q <= '0;   ci_rem_q <= '0;   idx_q <= '0;
      done_q <= 1'b0;      coord0_q <= '0;   coord1_q <= '0;   coord2_q <= '0;
      out_idx_q <= '0;     out_last_q <= 1'b0; out_valid_q <= 1'b0;
      cull_pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;  mode_q <= mode_d; o0_q <= o0_d;     o1_q <= o1_d;
      lvl_u_q <= lvl_u_d;  lvl_v_q <= lvl_v_d; q_u_q <= q_u_d; q_v_q <= q_v_d;
      r_u_q <= r_u_d;      r_v_q <= r_v_d;   div_rem_q <= div_rem_d;
      div_quo_q <= div_quo_d; div_cnt_q <= div_cnt_d; on_q <= on_d; in_q <= in_d;
      co_acc_q <= co_acc_d; ci_acc_q <= ci_acc_d; co_rem_q <= co_rem_d;
      ci_rem_q <= ci_rem_d; idx_q <= idx_d;  done_q <= done_d;
      coord0_q <= coord0_d; coord1_q <= coord1_d; coord2_q <= coord2_d;
      out_idx_q <= out_idx_d; out_last_q <= out_last_d; out_valid_q <= out_valid_d;
      cull_pulse_q <= cull_pulse_d;
    end
  end

  assign cfg_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign coord0     = 32'(coord0_q);
  assign coord1     = 32'(coord1_q);
  assign coord2     = 32'(coord2_q);
  assign out_idx    = out_idx_q;
  assign out_last   = out_last_q;
  assign out_valid  = out_valid_q;
  assign cull_pulse = cull_pulse_q;

endmodule
